// File: rtl/key_sched_pkg.sv
// Shared constants, FSM state type and debounce period helper for the key scheduler.
package key_sched_pkg;

  localparam int EVT_PRESS_BIT = 7;
  localparam int EVT_IDX_MSB   = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Number of clock cycles per debounce sample period.
  function automatic int deb_cycles_f(input int clk_freq, input int debounce_us);
    return clk_freq / 1000000 * debounce_us;
  endfunction

endpackage

// File: rtl/key_scheduler_if.sv
// Event byte stream with valid/ready handshake.
interface key_scheduler_if;
  logic [7:0] evt_data;
  logic       evt_valid;
  logic       evt_ready;

  modport master (output evt_data, output evt_valid, input evt_ready);
  modport slave  (input evt_data, input evt_valid, output evt_ready);
endinterface

// File: rtl/key_scheduler_debounce.sv
// Two-flop synchroniser plus tick-sampled debouncer for all key inputs.
module key_debounce #(
  parameter int NUM_KEYS   = 13,
  parameter int DEB_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_i,
  output logic [NUM_KEYS-1:0] stable_o
);

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q, sample_q, stable_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                tick;

  assign tick     = (cnt_q == CNT_W'(DEB_CYCLES - 1));
  assign stable_o = stable_q;

  // Metastability guard on the raw asynchronous levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= keys_i;
      sync2_q <= sync1_q;
    end
  end

  // Free-running tick counter shared by all keys.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + 1'b1;
  end

  // On each tick, a key's stable level follows only if this sample matches the previous one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_q <= '0;
      stable_q <= '0;
    end else if (tick) begin
      sample_q <= sync2_q;
      for (int i = 0; i < NUM_KEYS; i++)
        if (sync2_q[i] == sample_q[i]) stable_q[i] <= sync2_q[i];
    end
  end

endmodule

// File: rtl/key_scheduler.sv
// Debounced key events, round-robin arbitrated onto a byte stream, plus monophonic note output.
module key_scheduler
  import key_sched_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int DEBOUNCE_US = 1000,
  parameter int NUM_KEYS    = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  key_scheduler_if.master     evt,
  output logic                note_valid,
  output logic [3:0]          note_idx
);

  localparam int DEB_CYCLES = deb_cycles_f(CLK_FREQ, DEBOUNCE_US);

  logic [NUM_KEYS-1:0] stable, pending, reported_q;
  logic [3:0]          ptr_q, g_q, gnt;
  logic                gnt_vld;
  state_e              state_q;
  logic [7:0]          evt_data_q;
  logic                evt_valid_q;
  logic                note_valid_q;
  logic [3:0]          note_idx_q, note_idx_d;

  key_debounce #(.NUM_KEYS(NUM_KEYS), .DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk      (clk),
    .rst      (rst),
    .keys_i   (keys),
    .stable_o (stable)
  );

  // A key is pending while its debounced level differs from what was last sent.
  assign pending = stable ^ reported_q;

  // Round-robin search starting at ptr_q, wrapping at NUM_KEYS-1.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NUM_KEYS) j = j - NUM_KEYS;
      if (!gnt_vld && pending[j]) begin
        gnt     = 4'(j);
        gnt_vld = 1'b1;
      end
    end
  end

  // Event FSM: present one byte, hold it until accepted, then mark it reported.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      evt_data_q  <= '0;
      evt_valid_q <= 1'b0;
      g_q         <= '0;
      ptr_q       <= '0;
      reported_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (gnt_vld) begin
          evt_data_q  <= {stable[gnt], 3'b000, gnt};
          g_q         <= gnt;
          evt_valid_q <= 1'b1;
          state_q     <= SEND;
        end
        SEND: if (evt.evt_ready) begin
          // Record what was actually sent; a later change re-raises pending.
          reported_q[g_q] <= evt_data_q[EVT_PRESS_BIT];
          ptr_q           <= (g_q == 4'(NUM_KEYS - 1)) ? 4'd0 : g_q + 4'd1;
          evt_valid_q     <= 1'b0;
          state_q         <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign evt.evt_data  = evt_data_q;
  assign evt.evt_valid = evt_valid_q;

  // Highest-index held key wins.
  always_comb begin
    note_idx_d = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (stable[i]) note_idx_d = 4'(i);
  end

  // Register the note outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      note_valid_q <= 1'b0;
      note_idx_q   <= '0;
    end else begin
      note_valid_q <= |stable;
      note_idx_q   <= note_idx_d;
    end
  end

  assign note_valid = note_valid_q;
  assign note_idx   = note_idx_q;

endmodule
